// File: rtl/commit_buffer_if.sv
// ---------------------------------------------------------------------------
// commit_buffer_if
// Bundles the issue, writeback and commit signals of the commit buffer.
// The signal suffixes describe direction as seen by the buffer itself.
//   issue     : flush_i, issue_valid_i, issue_data_i -> issue_ready_o,
//               issue_trans_id_o (slot the next accepted issue occupies)
//   writeback : wb_valid_i, wb_trans_id_i, wb_result_i, wb_ex_valid_i
//   commit    : commit_valid_o, commit_data_o, commit_result_o,
//               commit_ex_valid_o, commit_trans_id_o (one entry per port)
//               <- commit_ack_i
// Modports: slave = the buffer, master = the pipeline driving it.
// ---------------------------------------------------------------------------
interface commit_buffer_if #(
   parameter int NR_ENTRIES      = 8,
   parameter int NR_COMMIT_PORTS = 2,
   parameter int DATA_W          = 64,
   parameter int XLEN            = 64
);
   localparam int TID_W = $clog2(NR_ENTRIES);

   logic                                   flush_i;
   logic                                   issue_valid_i;
   logic [DATA_W-1:0]                      issue_data_i;
   logic                                   issue_ready_o;
   logic [TID_W-1:0]                       issue_trans_id_o;
   logic                                   wb_valid_i;
   logic [TID_W-1:0]                       wb_trans_id_i;
   logic [XLEN-1:0]                        wb_result_i;
   logic                                   wb_ex_valid_i;
   logic [NR_COMMIT_PORTS-1:0]             commit_valid_o;
   logic [NR_COMMIT_PORTS-1:0][DATA_W-1:0] commit_data_o;
   logic [NR_COMMIT_PORTS-1:0][XLEN-1:0]   commit_result_o;
   logic [NR_COMMIT_PORTS-1:0]             commit_ex_valid_o;
   logic [NR_COMMIT_PORTS-1:0][TID_W-1:0]  commit_trans_id_o;
   logic [NR_COMMIT_PORTS-1:0]             commit_ack_i;

   modport slave (
      input  flush_i, issue_valid_i, issue_data_i,
      output issue_ready_o, issue_trans_id_o,
      input  wb_valid_i, wb_trans_id_i, wb_result_i, wb_ex_valid_i,
      output commit_valid_o, commit_data_o, commit_result_o,
      output commit_ex_valid_o, commit_trans_id_o,
      input  commit_ack_i
   );

   modport master (
      output flush_i, issue_valid_i, issue_data_i,
      input  issue_ready_o, issue_trans_id_o,
      output wb_valid_i, wb_trans_id_i, wb_result_i, wb_ex_valid_i,
      input  commit_valid_o, commit_data_o, commit_result_o,
      input  commit_ex_valid_o, commit_trans_id_o,
      output commit_ack_i
   );
endinterface

// File: rtl/commit_buffer.sv
// ---------------------------------------------------------------------------
// commit_buffer
// Circular in-order commit buffer. Instructions are allocated a slot at
// issue, results land out of order by slot index, and the oldest completed
// entries are presented on up to NR_COMMIT_PORTS commit ports in order.
// Ports:
//   clk_i  : clock, all state updates on the rising edge
//   rst_ni : asynchronous active-low reset
//   bus    : commit_buffer_if.slave (issue / writeback / commit groups)
// ---------------------------------------------------------------------------
module commit_buffer #(
   parameter int NR_ENTRIES      = 8,
   parameter int NR_COMMIT_PORTS = 2,
   parameter int DATA_W          = 64,
   parameter int XLEN            = 64
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   commit_buffer_if.slave   bus
);
   localparam int TID_W = $clog2(NR_ENTRIES);
   localparam int CNT_W = TID_W + 1;
   localparam int ACK_W = $clog2(NR_COMMIT_PORTS + 1);

   // Per-slot state flags and storage
   logic [NR_ENTRIES-1:0] issued_q, issued_d;
   logic [NR_ENTRIES-1:0] done_q, done_d;
   logic [NR_ENTRIES-1:0] ex_q, ex_d;
   logic [DATA_W-1:0]     data_q   [NR_ENTRIES];
   logic [XLEN-1:0]       result_q [NR_ENTRIES];

   // Pointers and occupancy
   logic [TID_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [TID_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;

   logic                        issue_ready;
   logic                        issue_fire;
   logic                        wb_fire;
   logic [NR_COMMIT_PORTS-1:0]  ack_eff;
   logic [ACK_W-1:0]            nr_acks;
   logic [TID_W-1:0]            port_idx [NR_COMMIT_PORTS];

   // Readiness looks at the registered count only, so a slot freed by an
   // ack this cycle cannot be reused until the next one.
   assign issue_ready          = count_q < CNT_W'(NR_ENTRIES);
   assign bus.issue_ready_o    = issue_ready;
   assign bus.issue_trans_id_o = wr_ptr_q;
   assign issue_fire           = bus.issue_valid_i & issue_ready;

   // A writeback only lands on a slot that is live and still waiting.
   assign wb_fire = bus.wb_valid_i & issued_q[bus.wb_trans_id_i]
                    & ~done_q[bus.wb_trans_id_i];

   // Commit presentation. valid_chain / ack_chain enforce that port i is
   // only valid (and only retired) when every older port is as well.
   // NOTE: every variable assigned here gets a default first, so no path
   // leaves a value unassigned and no latch is inferred.
   always_comb begin
      logic valid_chain;
      logic ack_chain;
      logic slot_ready;
      valid_chain           = 1'b1;
      ack_chain             = 1'b1;
      nr_acks               = '0;
      ack_eff               = '0;
      bus.commit_valid_o    = '0;
      bus.commit_data_o     = '0;
      bus.commit_result_o   = '0;
      bus.commit_ex_valid_o = '0;
      bus.commit_trans_id_o = '0;
      for (int i = 0; i < NR_COMMIT_PORTS; i++) begin
         port_idx[i] = rd_ptr_q + TID_W'(i);
         slot_ready  = issued_q[port_idx[i]] & done_q[port_idx[i]]
                       & (count_q > CNT_W'(i));
         bus.commit_valid_o[i]    = slot_ready & valid_chain;
         valid_chain              = bus.commit_valid_o[i];
         // Payload outputs follow the addressed slot whether valid or not.
         bus.commit_data_o[i]     = data_q[port_idx[i]];
         bus.commit_result_o[i]   = result_q[port_idx[i]];
         bus.commit_ex_valid_o[i] = ex_q[port_idx[i]];
         bus.commit_trans_id_o[i] = port_idx[i];
         ack_eff[i] = bus.commit_ack_i[i] & bus.commit_valid_o[i] & ack_chain;
         ack_chain  = ack_eff[i];
         if (ack_eff[i]) nr_acks = nr_acks + ACK_W'(1);
      end
   end

   // Next-state for flags, pointers and count; flush overrides everything.
   always_comb begin
      issued_d = issued_q;
      done_d   = done_q;
      ex_d     = ex_q;
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;
      if (bus.flush_i) begin
         issued_d = '0;
         done_d   = '0;
         rd_ptr_d = '0;
         wr_ptr_d = '0;
         count_d  = '0;
      end else begin
         // Issue slot and acked slots never coincide: that would need the
         // buffer to be both empty (no ack) and full (no issue).
         if (issue_fire) begin
            issued_d[wr_ptr_q] = 1'b1;
            done_d[wr_ptr_q]   = 1'b0;
            ex_d[wr_ptr_q]     = 1'b0;
            wr_ptr_d           = wr_ptr_q + TID_W'(1);
         end
         if (wb_fire) begin
            done_d[bus.wb_trans_id_i] = 1'b1;
            ex_d[bus.wb_trans_id_i]   = bus.wb_ex_valid_i;
         end
         for (int i = 0; i < NR_COMMIT_PORTS; i++) begin
            if (ack_eff[i]) begin
               issued_d[port_idx[i]] = 1'b0;
               done_d[port_idx[i]]   = 1'b0;
            end
         end
         rd_ptr_d = rd_ptr_q + TID_W'(nr_acks);
         count_d  = count_q + CNT_W'(issue_fire) - CNT_W'(nr_acks);
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values regardless of block ordering.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         issued_q <= '0;
         done_q   <= '0;
         ex_q     <= '0;
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         issued_q <= issued_d;
         done_q   <= done_d;
         ex_q     <= ex_d;
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
      end
   end

   // NOTE: payload storage has no reset; its contents are meaningless until
   // the issued/done flags (which are reset) mark a slot as live.
   always_ff @(posedge clk_i) begin
      if (!bus.flush_i && issue_fire) data_q[wr_ptr_q] <= bus.issue_data_i;
      if (!bus.flush_i && wb_fire) result_q[bus.wb_trans_id_i] <= bus.wb_result_i;
   end
endmodule

// File: tb/tb_commit_buffer.sv
// ---------------------------------------------------------------------------
// tb_commit_buffer
// Directed bench for commit_buffer with default parameters (8 entries,
// 2 commit ports). Expected values are written out by hand per scenario.
// ---------------------------------------------------------------------------
module tb_commit_buffer;
   localparam int NR_ENTRIES      = 8;
   localparam int NR_COMMIT_PORTS = 2;
   localparam int DATA_W          = 64;
   localparam int XLEN            = 64;

   logic clk_i  = 1'b0;
   logic rst_ni = 1'b0;

   int n_tests = 0;
   int n_fail  = 0;

   commit_buffer_if #(
      .NR_ENTRIES(NR_ENTRIES), .NR_COMMIT_PORTS(NR_COMMIT_PORTS),
      .DATA_W(DATA_W), .XLEN(XLEN)
   ) bus ();

   commit_buffer #(
      .NR_ENTRIES(NR_ENTRIES), .NR_COMMIT_PORTS(NR_COMMIT_PORTS),
      .DATA_W(DATA_W), .XLEN(XLEN)
   ) dut (
      .clk_i (clk_i),
      .rst_ni(rst_ni),
      .bus   (bus)
   );

   always #5 clk_i = ~clk_i;

   task automatic check(input string tag, input logic [63:0] act,
                        input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   // Advance one rising edge and settle 1 time unit past it.
   task automatic cycle();
      @(posedge clk_i);
      #1;
   endtask

   task automatic idle_inputs();
      bus.flush_i       = 1'b0;
      bus.issue_valid_i = 1'b0;
      bus.issue_data_i  = '0;
      bus.wb_valid_i    = 1'b0;
      bus.wb_trans_id_i = '0;
      bus.wb_result_i   = '0;
      bus.wb_ex_valid_i = 1'b0;
      bus.commit_ack_i  = '0;
   endtask

   task automatic do_issue(input logic [63:0] d);
      bus.issue_valid_i = 1'b1;
      bus.issue_data_i  = d;
      cycle();
      bus.issue_valid_i = 1'b0;
   endtask

   task automatic do_wb(input int tid, input logic [63:0] r, input logic ex);
      bus.wb_valid_i    = 1'b1;
      bus.wb_trans_id_i = 3'(tid);
      bus.wb_result_i   = r;
      bus.wb_ex_valid_i = ex;
      cycle();
      bus.wb_valid_i    = 1'b0;
      bus.wb_ex_valid_i = 1'b0;
   endtask

   task automatic do_ack(input logic [1:0] a);
      bus.commit_ack_i = a;
      cycle();
      bus.commit_ack_i = '0;
   endtask

   task automatic do_flush();
      bus.flush_i = 1'b1;
      cycle();
      bus.flush_i = 1'b0;
   endtask

   initial begin
      idle_inputs();

      // ---- reset state
      #2;
      check("rst_ready", bus.issue_ready_o, 1);
      check("rst_tid", bus.issue_trans_id_o, 0);
      check("rst_valid", bus.commit_valid_o, 0);
      cycle();
      rst_ni = 1'b1;
      cycle();
      check("post_rst_ready", bus.issue_ready_o, 1);
      check("post_rst_valid", bus.commit_valid_o, 0);

      // ---- fill: 8 issues, trans ids 0..7, full afterwards
      for (int k = 0; k < 8; k++) begin
         check($sformatf("fill_tid%0d", k), bus.issue_trans_id_o, 64'(k));
         check($sformatf("fill_ready%0d", k), bus.issue_ready_o, 1);
         do_issue(64'h100 + 64'(k));
      end
      check("full_ready", bus.issue_ready_o, 0);
      check("full_valid", bus.commit_valid_o, 0);

      // ---- full with simultaneous ack[0] and issue: issue refused
      do_wb(0, 64'hAA00, 1'b0);
      check("full_wb_valid", bus.commit_valid_o, 2'b01);
      check("full_wb_data", bus.commit_data_o[0], 64'h100);
      bus.issue_valid_i = 1'b1;
      bus.issue_data_i  = 64'hDEAD;
      do_ack(2'b01);
      bus.issue_valid_i = 1'b0;
      check("full_ack_ready", bus.issue_ready_o, 1);
      check("full_ack_tid", bus.issue_trans_id_o, 0);
      check("full_ack_valid", bus.commit_valid_o, 2'b00);
      check("full_ack_port0", bus.commit_trans_id_o[0], 1);
      do_issue(64'h555);  // count 7 -> 8
      check("refill_ready", bus.issue_ready_o, 0);
      do_flush();
      check("flush1_ready", bus.issue_ready_o, 1);
      check("flush1_tid", bus.issue_trans_id_o, 0);

      // ---- out-of-order writeback
      do_issue(64'hA);
      do_issue(64'hB);
      check("ooo_tid", bus.issue_trans_id_o, 2);
      do_wb(1, 64'hB1, 1'b1);
      check("ooo_valid_after_wb1", bus.commit_valid_o, 2'b00);
      do_wb(0, 64'hA0, 1'b0);
      check("ooo_valid_after_wb0", bus.commit_valid_o, 2'b11);
      check("ooo_data0", bus.commit_data_o[0], 64'hA);
      check("ooo_data1", bus.commit_data_o[1], 64'hB);
      check("ooo_res0", bus.commit_result_o[0], 64'hA0);
      check("ooo_res1", bus.commit_result_o[1], 64'hB1);
      check("ooo_ex", bus.commit_ex_valid_o, 2'b10);
      check("ooo_tid1", bus.commit_trans_id_o[1], 1);

      // ---- ack[1] alone is ignored
      do_ack(2'b10);
      check("ack10_valid", bus.commit_valid_o, 2'b11);
      check("ack10_port0", bus.commit_trans_id_o[0], 0);
      do_ack(2'b11);
      check("ack11_valid", bus.commit_valid_o, 2'b00);
      check("ack11_port0", bus.commit_trans_id_o[0], 2);
      check("ack11_ready", bus.issue_ready_o, 1);

      // ---- wrap: 11 entries one at a time
      do_flush();
      for (int k = 0; k < 11; k++) begin
         check($sformatf("wrap_tid%0d", k), bus.issue_trans_id_o, 64'(k % 8));
         do_issue(64'h200 + 64'(k));
         do_wb(k % 8, 64'h1000 + 64'(k), 1'b0);
         check($sformatf("wrap_valid%0d", k), bus.commit_valid_o, 2'b01);
         check($sformatf("wrap_res%0d", k), bus.commit_result_o[0],
               64'h1000 + 64'(k));
         check($sformatf("wrap_ctid%0d", k), bus.commit_trans_id_o[0],
               64'(k % 8));
         do_ack(2'b01);
         check($sformatf("wrap_empty%0d", k), bus.commit_valid_o, 2'b00);
      end
      check("wrap_final_tid", bus.issue_trans_id_o, 3);

      // ---- flush with concurrent issue, writeback and ack
      do_flush();
      for (int k = 0; k < 4; k++) do_issue(64'h300 + 64'(k));
      do_wb(0, 64'h3A, 1'b0);
      check("pre_flush_valid", bus.commit_valid_o, 2'b01);
      bus.flush_i       = 1'b1;
      bus.issue_valid_i = 1'b1;
      bus.issue_data_i  = 64'hBAD;
      bus.wb_valid_i    = 1'b1;
      bus.wb_trans_id_i = 3'd1;
      bus.wb_result_i   = 64'hBAD1;
      bus.commit_ack_i  = 2'b01;
      check("flush_cycle_ready", bus.issue_ready_o, 1);
      cycle();
      idle_inputs();
      check("flush_valid", bus.commit_valid_o, 2'b00);
      check("flush_tid", bus.issue_trans_id_o, 0);
      check("flush_ready", bus.issue_ready_o, 1);
      do_wb(3, 64'h5, 1'b0);  // stale, must not mark slot 3 done
      check("stale_valid", bus.commit_valid_o, 2'b00);
      for (int k = 0; k < 4; k++) do_issue(64'h400 + 64'(k));
      do_wb(0, 64'h40, 1'b0);
      do_wb(1, 64'h41, 1'b0);
      do_wb(2, 64'h42, 1'b0);
      check("post_flush_valid", bus.commit_valid_o, 2'b11);
      check("post_flush_res1", bus.commit_result_o[1], 64'h41);
      do_ack(2'b11);
      check("stale_slot3_valid", bus.commit_valid_o, 2'b01);
      check("stale_slot3_port1", bus.commit_trans_id_o[1], 3);
      do_wb(3, 64'h43, 1'b0);
      check("slot3_valid", bus.commit_valid_o, 2'b11);
      check("slot3_res", bus.commit_result_o[1], 64'h43);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/commit_buffer.md
COMMIT_BUFFER -- requirements
Module: commit_buffer

Interface
REQ-001 Parameter NR_ENTRIES, default 8: buffer depth; power of two, 4..16.
REQ-002 Parameter NR_COMMIT_PORTS, default 2: commit ports presented per cycle; 1 or 2.
REQ-003 Parameter DATA_W, default 64: opaque per-instruction payload width (pc, fu, op, rd packed by issue).
REQ-004 Parameter XLEN, default 64: result width; TID_W = log2(NR_ENTRIES).
REQ-005 clk_i  in  1  clock; one clock domain, all logic on rising edge.
REQ-006 rst_ni  in  1  reset; asynchronous assertion, active-low.
REQ-007 flush_i  in  1  discard all entries.
REQ-008 issue_valid_i  in  1  new instruction offered.
REQ-009 issue_data_i  in  DATA_W  instruction payload.
REQ-010 issue_ready_o  out  1  slot free; issue accepted when valid & ready.
REQ-011 issue_trans_id_o  out  TID_W  slot index the next accepted issue occupies.
REQ-012 wb_valid_i  in  1  writeback strobe.
REQ-013 wb_trans_id_i  in  TID_W  target slot.
REQ-014 wb_result_i  in  XLEN  result.
REQ-015 wb_ex_valid_i  in  1  instruction raised exception.
REQ-016 commit_valid_o  out  NR_COMMIT_PORTS  port i holds the i-th oldest entry, written back.
REQ-017 commit_data_o  out  NR_COMMIT_PORTS x DATA_W  payload per port.
REQ-018 commit_result_o  out  NR_COMMIT_PORTS x XLEN  result per port.
REQ-019 commit_ex_valid_o  out  NR_COMMIT_PORTS  exception flag per port.
REQ-020 commit_trans_id_o  out  NR_COMMIT_PORTS x TID_W  slot index per port.
REQ-021 commit_ack_i  in  NR_COMMIT_PORTS  commit consumer retires port i.

Function
REQ-022 Storage: circular buffer, read pointer, write pointer, occupancy count (TID_W+1 bits); per slot: issued, done, data, result, ex_valid.
REQ-023 issue_ready_o = registered count < NR_ENTRIES; no same-cycle bypass of freed slots.
REQ-024 Accepted issue: slot[wr_ptr] written with issued=1, done=0, ex_valid=0; wr_ptr increments, wrapping NR_ENTRIES-1 -> 0.
REQ-025 issue_trans_id_o = wr_ptr, combinational from registered state.
REQ-026 Writeback with issued=1 and done=0 at target slot: result, ex_valid stored, done=1 next edge; otherwise ignored.
REQ-027 Writeback-to-commit latency one cycle: commit_valid_o reflects done from register only, no wb bypass.
REQ-028 Port i presents slot (rd_ptr+i) mod NR_ENTRIES; commit_valid_o[i] = issued & done of that slot & count > i.
REQ-029 commit_valid_o[1] SHALL require commit_valid_o[0] (in-order presentation).
REQ-030 Effective ack: ack[0] & valid[0]; ack[1] & valid[1] & effective ack[0]; other acks ignored.
REQ-031 Each effective ack clears issued/done of its slot; rd_ptr advances by effective-ack count, wrapping.
REQ-032 count_next = count + issue accepted - effective acks; simultaneous issue and ack at full or empty count handled by this equation.
REQ-033 flush_i: next edge clears all issued/done, rd_ptr, wr_ptr, count to 0; flush has priority over same-cycle issue, writeback, ack; issue_ready_o unaffected combinationally during flush cycle.
REQ-034 Outputs not gated by valid (data, result, trans_id) SHALL still reflect addressed slot contents; consumers qualify with commit_valid_o.

Reset
REQ-035 rst_ni low: pointers, count, all issued/done/ex_valid flags cleared asynchronously; data/result storage need no reset.
REQ-036 During and after reset: issue_ready_o=1, issue_trans_id_o=0, commit_valid_o=0.

Verification
REQ-037 Fill: 8 issues no wb -> issue_ready_o=0 after 8th, trans_ids 0..7, commit_valid_o=00.
REQ-038 Out-of-order wb: issue A(0),B(1); wb tid1 then tid0 -> valid=00 until tid0 wb, next cycle valid=11; ack=11 -> count 0.
REQ-039 Ack[1] without ack[0]: two done entries, ack=10 -> nothing retired, rd_ptr unchanged.
REQ-040 Wrap: issue/commit 11 entries one at a time -> 9th-11th get trans_id 0,1,2; results match order.
REQ-041 Full simultaneous: count=8, ack[0] and issue_valid same cycle -> issue not accepted, count becomes 7, ready=1 next cycle.
REQ-042 Flush with concurrent issue, wb, ack -> next cycle count=0, valid=00, trans_id=0; stale wb to tid 3 afterwards ignored.
